// File: rtl/if_id_pkg.sv
// Shared pipeline defines (precompiled.v set) and the IF/ID fetch-queue types.
`ifndef PRECOMPILED_V
`define PRECOMPILED_V
`define RstEnable   1'b1
`define RstDisable  1'b0
`define ZeroWord    32'h00000000
`define STOP        1'b1
`define NOSTOP      1'b0
`define InstAddrBus 31:0
`define InstBus     31:0
`define CtrlBus     5:0
`endif

package if_id_pkg;
  localparam logic [1:0] QDEPTH = 2'd2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        filled;
  } fetch_ent_t;

  typedef enum logic [1:0] {
    ID_HOLD,
    ID_BUBBLE,
    ID_LOAD
  } id_act_e;
endpackage

// File: rtl/if_fifo.sv
// Two-entry in-order fetch queue. Filled entries always form a prefix, so the
// oldest unfilled entry is slot 0 if it is unfilled, otherwise slot 1.
module if_fifo
  import if_id_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  logic [31:0] push_pc_i,
  input  logic        fill_i,
  input  logic [31:0] fill_inst_i,
  input  logic        pop_i,
  input  logic        clear_i,
  output logic [31:0] head_pc_o,
  output logic [31:0] head_inst_o,
  output logic        head_rdy_o,
  output logic [1:0]  count_o,
  output logic [1:0]  unfilled_o
);
  fetch_ent_t [1:0] ent_q, ent_d, ent_f;
  logic [1:0] cnt_q, cnt_d, cnt_p;
  logic       full, fill0, fill1, do_pop, do_push;

  assign full    = (cnt_q == QDEPTH);
  assign fill0   = fill_i && (cnt_q != 2'd0) && !ent_q[0].filled;
  assign fill1   = fill_i && !fill0 && full && !ent_q[1].filled;
  assign do_pop  = pop_i && head_rdy_o;
  // The slot count is sampled before the pop so a full queue never pushes.
  assign do_push = push_i && !full;

  always_comb begin
    ent_f = ent_q;
    if (fill0) begin
      ent_f[0].inst   = fill_inst_i;
      ent_f[0].filled = 1'b1;
    end
    if (fill1) begin
      ent_f[1].inst   = fill_inst_i;
      ent_f[1].filled = 1'b1;
    end
    ent_d = ent_f;
    cnt_p = cnt_q;
    if (do_pop) begin
      ent_d[0] = ent_f[1];
      ent_d[1] = '0;
      cnt_p    = cnt_q - 2'd1;
    end
    cnt_d = cnt_p;
    if (do_push) begin
      ent_d[cnt_p[0]].pc     = push_pc_i;
      ent_d[cnt_p[0]].inst   = `ZeroWord;
      ent_d[cnt_p[0]].filled = 1'b0;
      cnt_d                  = cnt_p + 2'd1;
    end
    if (clear_i) begin
      ent_d = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == `RstEnable) begin
      ent_q <= '0;
      cnt_q <= '0;
    end else begin
      ent_q <= ent_d;
      cnt_q <= cnt_d;
    end
  end

  assign head_pc_o   = ent_q[0].pc;
  assign head_inst_o = ent_q[0].inst;
  assign head_rdy_o  = (cnt_q != 2'd0) && ent_q[0].filled;
  assign count_o     = cnt_q;
  assign unfilled_o  = {1'b0, (cnt_q != 2'd0) && !ent_q[0].filled}
                     + {1'b0, full && !ent_q[1].filled};
endmodule

// File: rtl/if_id.sv
// IF/ID stage: fetch queue plus ID output register, with post-flush drop of
// stale memory returns. Optional bubble counter under IF_ID_PERF_EN.
module if_id
  import if_id_pkg::*;
#(
  parameter logic [31:0] NOP_INST = 32'h00000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [`InstAddrBus] pc,
  input  logic                ce,
  input  logic [`InstBus]     rom_inst,
  input  logic                rom_valid,
  input  logic [`CtrlBus]     stall,
  input  logic                flush,
  output logic [`InstAddrBus] id_pc,
  output logic [`InstBus]     id_inst,
  output logic                id_valid,
  output logic                stallreq_if
`ifdef IF_ID_PERF_EN
  ,
  output logic [31:0]         perf_bubbles
`endif
);
  logic [1:0]  cnt, unfilled, drop_q, drop_d;
  logic        push, fill, pop, head_rdy;
  logic [31:0] head_pc, head_inst;
  logic [31:0] id_pc_q, id_pc_d, id_inst_q, id_inst_d;
  logic        id_valid_q, id_valid_d;
  logic        unused_stall;
  id_act_e     act;

  assign unused_stall = ^stall[5:3];

  assign push = ce && (stall[0] == `NOSTOP) && !flush;
  assign fill = rom_valid && (drop_q == 2'd0);
  assign pop  = (act == ID_LOAD);

  if_fifo u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .push_pc_i  (pc),
    .fill_i     (fill),
    .fill_inst_i(rom_inst),
    .pop_i      (pop),
    .clear_i    (flush),
    .head_pc_o  (head_pc),
    .head_inst_o(head_inst),
    .head_rdy_o (head_rdy),
    .count_o    (cnt),
    .unfilled_o (unfilled)
  );

  always_comb begin
    act = ID_HOLD;
    if (flush)                   act = ID_BUBBLE;
    else if (stall[1] == `NOSTOP) act = head_rdy ? ID_LOAD : ID_BUBBLE;
    else if (stall[2] == `NOSTOP) act = ID_BUBBLE;
  end

  // On flush, every request still unanswered after this edge's return must be discarded.
  always_comb begin
    drop_d = drop_q;
    if (flush)
      drop_d = unfilled - {1'b0, fill && (unfilled != 2'd0)};
    else if (rom_valid && (drop_q != 2'd0))
      drop_d = drop_q - 2'd1;
  end

  always_comb begin
    id_pc_d    = id_pc_q;
    id_inst_d  = id_inst_q;
    id_valid_d = id_valid_q;
    case (act)
      ID_LOAD: begin
        id_pc_d    = head_pc;
        id_inst_d  = head_inst;
        id_valid_d = 1'b1;
      end
      ID_BUBBLE: begin
        id_pc_d    = `ZeroWord;
        id_inst_d  = NOP_INST;
        id_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == `RstEnable) begin
      drop_q     <= 2'd0;
      id_pc_q    <= `ZeroWord;
      id_inst_q  <= NOP_INST;
      id_valid_q <= 1'b0;
    end else begin
      drop_q     <= drop_d;
      id_pc_q    <= id_pc_d;
      id_inst_q  <= id_inst_d;
      id_valid_q <= id_valid_d;
    end
  end

  assign id_pc       = id_pc_q;
  assign id_inst     = id_inst_q;
  assign id_valid    = id_valid_q;
  assign stallreq_if = (cnt == QDEPTH);

`ifdef IF_ID_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst == `RstEnable)   perf_q <= 32'd0;
    else if (act == ID_BUBBLE) perf_q <= perf_q + 32'd1;
  end

  assign perf_bubbles = perf_q;
`endif
endmodule

// File: tb/tb_if_id.sv
// Directed bench for if_id: fetch stream, memory stall, IF stall, ID hold,
// flush-drop, async reset, and (with IF_ID_PERF_EN) bubble counter wrap.
module tb_if_id;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = '0;
  logic        ce = 1'b0;
  logic [31:0] rom_inst = '0;
  logic        rom_valid = 1'b0;
  logic [5:0]  stall = '0;
  logic        flush = 1'b0;
  logic [31:0] id_pc, id_inst;
  logic        id_valid, stallreq_if;
`ifdef IF_ID_PERF_EN
  logic [31:0] perf_bubbles;
`endif

  int n_chk = 0;
  int n_pass = 0;

  if_id #(.NOP_INST(NOP)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .ce         (ce),
    .rom_inst   (rom_inst),
    .rom_valid  (rom_valid),
    .stall      (stall),
    .flush      (flush),
    .id_pc      (id_pc),
    .id_inst    (id_inst),
    .id_valid   (id_valid),
    .stallreq_if(stallreq_if)
`ifdef IF_ID_PERF_EN
    ,
    .perf_bubbles(perf_bubbles)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ri(input logic [31:0] p);
    return 32'h1000_0000 | p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic step(input logic c, input logic [31:0] p, input logic rv,
                      input logic [31:0] inst, input logic [5:0] st, input logic fl);
    ce = c; pc = p; rom_valid = rv; rom_inst = inst; stall = st; flush = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idb(input string tag);
    chk({tag, ".valid"}, 32'(id_valid), 32'd0);
    chk({tag, ".pc"},    id_pc,         32'd0);
    chk({tag, ".inst"},  id_inst,       NOP);
  endtask

  task automatic idv(input string tag, input logic [31:0] p);
    chk({tag, ".valid"}, 32'(id_valid), 32'd1);
    chk({tag, ".pc"},    id_pc,         p);
    chk({tag, ".inst"},  id_inst,       ri(p));
  endtask

  task automatic sr(input string tag, input logic e);
    chk({tag, ".sr"}, 32'(stallreq_if), 32'(e));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    @(posedge clk); @(posedge clk); #1;
    idb("rst"); sr("rst", 1'b0);
`ifdef IF_ID_PERF_EN
    chk("rst.perf", perf_bubbles, 32'd0);
`endif
    rst = 1'b0;

    // fetch stream 0/4/8 with 1-cycle returns
    step(1, 32'h0, 0, 0,        6'b0, 0); idb("s1"); sr("s1", 0);
    step(1, 32'h4, 1, ri(0),    6'b0, 0); idb("s2"); sr("s2", 1);
    step(1, 32'h8, 1, ri(4),    6'b0, 0); idv("s3", 32'h0); sr("s3", 0);
    step(1, 32'h8, 0, 0,        6'b0, 0); idv("s4", 32'h4);
    step(0, 32'h8, 1, ri(8),    6'b0, 0); idb("s5");
    step(0, 32'h0, 0, 0,        6'b0, 0); idv("s6", 32'h8);

    // memory stall: queue fills, third request blocked
    step(1, 32'hC,  0, 0,       6'b0, 0); idb("m1"); sr("m1", 0);
    step(1, 32'h10, 0, 0,       6'b0, 0); idb("m2"); sr("m2", 1);
    step(1, 32'h14, 0, 0,       6'b0, 0); idb("m3"); sr("m3", 1);
    step(0, 32'h0,  1, ri(32'hC),  6'b0, 0); idb("m4"); sr("m4", 1);
    step(0, 32'h0,  1, ri(32'h10), 6'b0, 0); idv("m5", 32'hC); sr("m5", 0);
    step(0, 32'h0,  0, 0,       6'b0, 0); idv("m6", 32'h10);
    step(0, 32'h0,  1, ri(32'h14), 6'b0, 0); idb("m7"); sr("m7", 0);
    step(0, 32'h0,  0, 0,       6'b0, 0); idb("m8");

    // IF stall: bubbles, no pop, no push
    step(1, 32'h18, 0, 0,       6'b0, 0); idb("f1");
    step(0, 32'h0,  1, ri(32'h18), 6'b0, 0); idb("f2");
    step(1, 32'h1C, 0, 0,       6'b000011, 0); idb("f3"); sr("f3", 0);
    step(1, 32'h1C, 0, 0,       6'b000011, 0); idb("f4"); sr("f4", 0);
    step(0, 32'h0,  0, 0,       6'b0, 0); idv("f5", 32'h18);

    // ID hold
    for (int i = 0; i < 3; i++) begin
      step(1, 32'h20, 0, 0, 6'b000111, 0); idv($sformatf("h%0d", i), 32'h18);
    end
    sr("h", 0);
    step(0, 32'h0, 0, 0, 6'b0, 0); idb("h3");

    // flush with two unfilled entries: two stale returns dropped
    step(1, 32'h24, 0, 0, 6'b0, 0); idb("k1");
    step(1, 32'h28, 0, 0, 6'b0, 0); idb("k2"); sr("k2", 1);
    step(1, 32'h2C, 0, 0, 6'b0, 1); idb("k3"); sr("k3", 0);
    step(1, 32'h40, 0, 0, 6'b0, 0); idb("k4"); sr("k4", 0);
    step(0, 32'h0, 1, ri(32'h24), 6'b0, 0); idb("k5");
    step(0, 32'h0, 1, ri(32'h28), 6'b0, 0); idb("k6");
    step(0, 32'h0, 1, ri(32'h40), 6'b0, 0); idb("k7");
    step(0, 32'h0, 0, 0, 6'b0, 0); idv("k8", 32'h40);

    // flush coinciding with a return: only one stale return left
    step(1, 32'h44, 0, 0, 6'b0, 0); idb("l1");
    step(1, 32'h48, 0, 0, 6'b0, 0); idb("l2"); sr("l2", 1);
    step(1, 32'h4C, 1, ri(32'h44), 6'b0, 1); idb("l3"); sr("l3", 0);
    step(1, 32'h50, 0, 0, 6'b0, 0); idb("l4");
    step(0, 32'h0, 1, ri(32'h48), 6'b0, 0); idb("l5");
    step(0, 32'h0, 1, ri(32'h50), 6'b0, 0); idb("l6");
    step(0, 32'h0, 0, 0, 6'b0, 0); idv("l7", 32'h50);

    // async reset mid-operation abandons requests without dropping
    step(1, 32'h54, 0, 0, 6'b0, 0); idb("r1");
    step(1, 32'h58, 1, ri(32'h54), 6'b0, 0); idb("r2"); sr("r2", 1);
    step(0, 32'h0, 0, 0, 6'b0, 0); idv("r3", 32'h54);
    #2 rst = 1'b1;
    #1 idb("r4"); sr("r4", 0);
    @(posedge clk); #1 rst = 1'b0;
    step(1, 32'h60, 1, ri(32'h58), 6'b0, 0); idb("r5"); sr("r5", 0);
    step(0, 32'h0, 1, ri(32'h60), 6'b0, 0); idb("r6");
    step(0, 32'h0, 0, 0, 6'b0, 0); idv("r7", 32'h60);

`ifdef IF_ID_PERF_EN
    force dut.perf_q = 32'hFFFF_FFFE;
    #1 release dut.perf_q;
    step(0, 32'h0, 0, 0, 6'b0, 0); chk("p1.perf", perf_bubbles, 32'hFFFF_FFFF);
    step(0, 32'h0, 0, 0, 6'b0, 0); chk("p2.perf", perf_bubbles, 32'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
